// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
// Control bundle groups the per-stage enables, flushes and PC select.
package pipe_stall_ctrl_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;
    localparam logic [1:0] PCSRC_EXC = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic       pc_we;
        logic       ifid_we;
        logic       idex_we;
        logic       exmem_we;
        logic       ifid_fl;
        logic       idex_fl;
        logic       exmem_fl;
        logic       memwb_fl;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = ctrl_t'(10'b1111_0000_00);

    // Mul/div hold: front end frozen, EX result bubbled into MEM.
    function automatic ctrl_t md_stall();
        ctrl_t c;
        c          = CTRL_RUN;
        c.pc_we    = 1'b0;
        c.ifid_we  = 1'b0;
        c.idex_we  = 1'b0;
        c.exmem_fl = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_perf_counter.sv
// Free-running event counter with enable; wraps at 2^W.
module pipe_stall_ctrl_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage core: hazard priority,
// mul/div latency counter, dmem-wait watchdog and perf counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MD_LATENCY  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             exc_req,
    input  logic             ex_md_start,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             PC_Wr_en,
    output logic             IF_ID_Wr_en,
    output logic             ID_EX_Wr_en,
    output logic             EX_MEM_Wr_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_flush,
    output logic [1:0]       pc_src,
    output logic             md_busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int MDC_W   = $clog2(MD_LATENCY + 1);
    localparam int MD_INIT = (MD_LATENCY >= 3) ? MD_LATENCY - 3 : 0;
    localparam int WC_W    = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    state_e            ret_q, ret_d;
    state_e            eff;
    logic [MDC_W-1:0]  md_cnt_q, md_cnt_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              md_done_q, md_done_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              in_mw, mem_stall, md_go;
    ctrl_t             ctl;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            ret_q         <= ST_RUN;
            md_cnt_q      <= '0;
            wait_cnt_q    <= '0;
            md_done_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            md_cnt_q      <= md_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            md_done_q     <= md_done_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        ctl           = CTRL_RUN;
        state_d       = state_q;
        ret_d         = ret_q;
        md_cnt_d      = md_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        md_done_d     = md_done_q;
        mem_timeout_d = mem_timeout_q;
        in_mw         = (state_q == ST_MEM_WAIT);
        // The ready cycle of a memory wait is decided as the return state.
        eff           = in_mw ? ret_q : state_q;
        mem_stall     = in_mw ? !dmem_ready : (mem_req && !dmem_ready);
        md_go         = ex_md_start && !md_done_q && (MD_LATENCY >= 2);

        if (mem_stall) begin
            ctl.pc_we    = 1'b0;
            ctl.ifid_we  = 1'b0;
            ctl.idex_we  = 1'b0;
            ctl.exmem_we = 1'b0;
            ctl.memwb_fl = 1'b1;
            state_d      = ST_MEM_WAIT;
            if (!in_mw) begin
                ret_d = state_q;
            end
            if (wait_cnt_q != WC_W'(MEM_TIMEOUT)) begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
            if (wait_cnt_d == WC_W'(MEM_TIMEOUT)) begin
                mem_timeout_d = 1'b1;
            end
        end else begin
            wait_cnt_d = '0;
            state_d    = ST_RUN;
            if (exc_req) begin
                ctl.ifid_fl  = 1'b1;
                ctl.idex_fl  = 1'b1;
                ctl.exmem_fl = 1'b1;
                ctl.pc_src   = PCSRC_EXC;
                md_cnt_d     = '0;
                md_done_d    = 1'b0;
            end else if (eff == ST_MD_WAIT) begin
                ctl = md_stall();
                if (md_cnt_q == '0) begin
                    md_done_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q - MDC_W'(1);
                    state_d  = ST_MD_WAIT;
                end
            end else if (md_go) begin
                ctl = md_stall();
                if (MD_LATENCY >= 3) begin
                    state_d  = ST_MD_WAIT;
                    md_cnt_d = MDC_W'(MD_INIT);
                end else begin
                    md_done_d = 1'b1;
                end
            end else if (branch_taken) begin
                ctl.ifid_fl = 1'b1;
                ctl.idex_fl = 1'b1;
                ctl.pc_src  = PCSRC_BR;
            end else if (load_use_hazard) begin
                ctl.pc_we   = 1'b0;
                ctl.ifid_we = 1'b0;
                ctl.idex_fl = 1'b1;
            end else if (jump_id) begin
                ctl.ifid_fl = 1'b1;
                ctl.pc_src  = PCSRC_JMP;
            end
            if (ctl.idex_we) begin
                md_done_d = 1'b0;
            end
        end

        if (!reset) begin
            ctl = CTRL_RUN;
        end
    end

    assign PC_Wr_en     = ctl.pc_we;
    assign IF_ID_Wr_en  = ctl.ifid_we;
    assign ID_EX_Wr_en  = ctl.idex_we;
    assign EX_MEM_Wr_en = ctl.exmem_we;
    assign IF_ID_flush  = ctl.ifid_fl;
    assign ID_EX_flush  = ctl.idex_fl;
    assign EX_MEM_flush = ctl.exmem_fl;
    assign MEM_WB_flush = ctl.memwb_fl;
    assign pc_src       = ctl.pc_src;
    assign md_busy      = (state_q == ST_MD_WAIT);
    assign mem_timeout  = mem_timeout_q;

    pipe_stall_ctrl_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (!ctl.pc_we),
        .count_o (stall_cycles)
    );

    pipe_stall_ctrl_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (ctl.ifid_fl | ctl.idex_fl | ctl.exmem_fl | ctl.memwb_fl),
        .count_o (flush_events)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench: driver queues expected outputs per cycle,
// monitor pops and compares on the falling edge.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_use_hazard, branch_taken, jump_id, exc_req;
    logic        ex_md_start, mem_req, dmem_ready;
    logic        PC_Wr_en, IF_ID_Wr_en, ID_EX_Wr_en, EX_MEM_Wr_en;
    logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
    logic [1:0]  pc_src;
    logic        md_busy, mem_timeout;
    logic [31:0] stall_cycles, flush_events;

    logic        b_pc, b_ifid, b_idex, b_exmem;
    logic        b_fifid, b_fidex, b_fexmem, b_fmemwb;
    logic [1:0]  b_pc_src;
    logic        b_md_busy, b_mem_timeout;
    logic [31:0] b_stall, b_flush;

    always #5 clk = ~clk;

    pipe_stall_ctrl u_dut (
        .clk(clk), .reset(reset),
        .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .jump_id(jump_id), .exc_req(exc_req), .ex_md_start(ex_md_start),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .PC_Wr_en(PC_Wr_en), .IF_ID_Wr_en(IF_ID_Wr_en),
        .ID_EX_Wr_en(ID_EX_Wr_en), .EX_MEM_Wr_en(EX_MEM_Wr_en),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
        .pc_src(pc_src), .md_busy(md_busy), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipe_stall_ctrl #(.MEM_TIMEOUT(3)) u_dut_to (
        .clk(clk), .reset(reset),
        .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .jump_id(jump_id), .exc_req(exc_req), .ex_md_start(ex_md_start),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .PC_Wr_en(b_pc), .IF_ID_Wr_en(b_ifid),
        .ID_EX_Wr_en(b_idex), .EX_MEM_Wr_en(b_exmem),
        .IF_ID_flush(b_fifid), .ID_EX_flush(b_fidex),
        .EX_MEM_flush(b_fexmem), .MEM_WB_flush(b_fmemwb),
        .pc_src(b_pc_src), .md_busy(b_md_busy), .mem_timeout(b_mem_timeout),
        .stall_cycles(b_stall), .flush_events(b_flush)
    );

    typedef struct {
        string       nm;
        logic [9:0]  ctl;
        logic [2:0]  st;
        logic        chk;
        logic [31:0] sc;
        logic [31:0] fe;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] acc_sc = '0;
    logic [31:0] acc_fe = '0;

    // in_v = {reset, lu, br, jmp, exc, md, mreq, drdy}
    // ctl  = {PC,IFID,IDEX,EXMEM enables, IFID,IDEX,EXMEM,MEMWB flushes, pc_src}
    // st   = {md_busy, mem_timeout, mem_timeout of MEM_TIMEOUT=3 copy}
    task automatic v(input string nm, input logic [7:0] in_v,
                     input logic [9:0] ctl, input logic [2:0] st,
                     input logic chk);
        exp_t e;
        @(posedge clk);
        #1;
        {reset, load_use_hazard, branch_taken, jump_id,
         exc_req, ex_md_start, mem_req, dmem_ready} = in_v;
        e.nm  = nm;
        e.ctl = ctl;
        e.st  = st;
        e.chk = chk;
        e.sc  = acc_sc;
        e.fe  = acc_fe;
        q.push_back(e);
        if (!in_v[7]) begin
            acc_sc = '0;
            acc_fe = '0;
        end else begin
            acc_sc = acc_sc + {31'd0, !ctl[9]};
            acc_fe = acc_fe + {31'd0, |ctl[5:2]};
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [9:0] act;
        logic [2:0] ast;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {PC_Wr_en, IF_ID_Wr_en, ID_EX_Wr_en, EX_MEM_Wr_en,
                       IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
                       pc_src};
                n_vec++;
                if (act !== e.ctl) begin
                    n_bad++;
                    $display("FAIL %s ctl: got %b want %b", e.nm, act, e.ctl);
                end
                if (e.chk) begin
                    ast = {md_busy, mem_timeout, b_mem_timeout};
                    n_vec++;
                    if (ast !== e.st || stall_cycles !== e.sc ||
                        flush_events !== e.fe) begin
                        n_bad++;
                        $display("FAIL %s state: got st=%b stall=%0d flush=%0d want st=%b stall=%0d flush=%0d",
                                 e.nm, ast, stall_cycles, flush_events,
                                 e.st, e.sc, e.fe);
                    end
                end
            end
        end
    end

    initial begin : driver
        {reset, load_use_hazard, branch_taken, jump_id,
         exc_req, ex_md_start, mem_req, dmem_ready} = 8'b0000_0001;
        v("rst_hazard", 8'b0101_0001, 10'b1111_0000_00, 3'b000, 1'b0);
        v("rst_idle",   8'b0000_0001, 10'b1111_0000_00, 3'b000, 1'b0);
        v("reset_out",  8'b1000_0001, 10'b1111_0000_00, 3'b000, 1'b1);
        v("lu_jmp",     8'b1101_0001, 10'b0011_0100_00, 3'b000, 1'b1);
        v("after_lu",   8'b1000_0001, 10'b1111_0000_00, 3'b000, 1'b1);
        v("md_start",   8'b1000_0101, 10'b0001_0010_00, 3'b000, 1'b1);
        v("md_wait1",   8'b1000_0101, 10'b0001_0010_00, 3'b100, 1'b1);
        v("md_wait2",   8'b1000_0101, 10'b0001_0010_00, 3'b100, 1'b1);
        v("md_release", 8'b1000_0101, 10'b1111_0000_00, 3'b000, 1'b1);
        v("md_restart", 8'b1000_0101, 10'b0001_0010_00, 3'b000, 1'b1);
        v("md_wait_b",  8'b1000_0001, 10'b0001_0010_00, 3'b100, 1'b1);
        v("exc_in_md",  8'b1010_1001, 10'b1111_1110_11, 3'b100, 1'b1);
        v("after_exc",  8'b1000_0001, 10'b1111_0000_00, 3'b000, 1'b1);
        v("branch",     8'b1111_0001, 10'b1111_1100_01, 3'b000, 1'b1);
        v("jump",       8'b1001_0001, 10'b1111_1000_10, 3'b000, 1'b1);
        v("mw1",        8'b1000_0010, 10'b0000_0001_00, 3'b000, 1'b1);
        v("mw2",        8'b1000_0010, 10'b0000_0001_00, 3'b000, 1'b1);
        v("mw3_exc",    8'b1010_1010, 10'b0000_0001_00, 3'b000, 1'b1);
        v("mw4",        8'b1000_0010, 10'b0000_0001_00, 3'b001, 1'b1);
        v("mw5",        8'b1000_0010, 10'b0000_0001_00, 3'b001, 1'b1);
        v("mw_done",    8'b1000_0011, 10'b1111_0000_00, 3'b001, 1'b1);
        v("to_sticky",  8'b1000_0001, 10'b1111_0000_00, 3'b001, 1'b1);
        v("md2_start",  8'b1000_0101, 10'b0001_0010_00, 3'b001, 1'b1);
        v("md2_memw",   8'b1000_0010, 10'b0000_0001_00, 3'b101, 1'b1);
        v("md2_resume", 8'b1000_0011, 10'b0001_0010_00, 3'b001, 1'b1);
        v("md2_last",   8'b1000_0001, 10'b0001_0010_00, 3'b101, 1'b1);
        v("md2_rel",    8'b1000_0101, 10'b1111_0000_00, 3'b001, 1'b1);
        v("rst2",       8'b0100_0001, 10'b1111_0000_00, 3'b000, 1'b0);
        v("post_rst2",  8'b1000_0001, 10'b1111_0000_00, 3'b000, 1'b1);
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
